// File: rtl/inst_fetch_resp.sv
// inst_fetch_resp: instruction-memory responder for the fetch stage.
//
// A request (ce with pc) is taken in IDLE. The addressed 32-bit word comes back
// LATENCY cycles later as a one-cycle inst_valid pulse. fetch_err qualifies the
// pulse. stall_req is high while a fetch is outstanding. flush aborts an
// outstanding fetch. A write port (we/waddr/wdata) preloads the word store.
//
// Request handshake: a request is taken on a posedge where the block is IDLE,
// ce=1 and flush=0. stall_req=1 means "not ready": ce and pc are ignored while
// it is high. Each taken request produces exactly one inst_valid pulse, unless
// flush or reset aborts that request first.
//
// Optional build macro FETCH_HIT_EN: adds a one-entry tag of the last good
// fetch address. A repeat fetch of that address then answers on its accept
// edge.
//
// Ports:
//   clk        clock, all state changes on posedge
//   rst        synchronous reset, active-low
//   ce, pc     fetch request enable and byte address
//   flush      abort any outstanding fetch; block new requests
//   we, waddr, wdata  store write port (byte address, same map as pc)
//   inst       fetched instruction (holds between responses)
//   inst_valid one-cycle pulse when inst is new
//   stall_req  high while a fetch is outstanding
//   fetch_err  qualifies inst_valid: pc misaligned or out of range
module inst_fetch_resp #(
  parameter int          LATENCY   = 3,
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic [31:0] pc,
  input  logic        flush,
  input  logic        we,
  input  logic [31:0] waddr,
  input  logic [31:0] wdata,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic        stall_req,
  output logic        fetch_err
);

  localparam int          IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] addr_q;
  logic [31:0] mem [DEPTH];

  logic          hit;
  logic          accept, fast, slow_done, resp_fire;
  logic [31:0]   resp_addr, resp_off, wr_off;
  logic          resp_bad, wr_ok;
  logic [IW-1:0] resp_idx, wr_idx;

  // A response comes from the live pc when it completes on the accept edge.
  // Otherwise it comes from the address latched at accept.
  assign accept    = (state == IDLE) && ce && !flush;
  assign fast      = accept && ((LATENCY == 1) || hit);
  assign slow_done = (state == BUSY) && !flush && (cnt == 4'd1);
  assign resp_fire = fast || slow_done;
  assign resp_addr = (state == IDLE) ? pc : addr_q;

  // The range check uses the full 32-bit offset before truncation to an
  // index. Without this, an address just past the end would alias onto word 0.
  assign resp_off = resp_addr - BASE_ADDR;
  assign resp_bad = (resp_addr[1:0] != 2'b00) || (resp_addr < BASE_ADDR) ||
                    ((resp_off >> 2) >= 32'(DEPTH));
  assign resp_idx = resp_off[IW+1:2];

  assign wr_off = waddr - BASE_ADDR;
  assign wr_ok  = we && (waddr[1:0] == 2'b00) && (waddr >= BASE_ADDR) &&
                  ((wr_off >> 2) < 32'(DEPTH));
  assign wr_idx = wr_off[IW+1:2];

  // Store: not reset. A write and a response read on the same edge returns the
  // old word, because both use non-blocking updates.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_idx] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      addr_q     <= 32'd0;
      inst       <= NOP;
      inst_valid <= 1'b0;
      stall_req  <= 1'b0;
      fetch_err  <= 1'b0;
    end else begin
      inst_valid <= 1'b0;
      if (resp_fire) begin
        inst       <= resp_bad ? NOP : mem[resp_idx];
        fetch_err  <= resp_bad;
        inst_valid <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            addr_q <= pc;
            if (!fast) begin
              state     <= BUSY;
              cnt       <= 4'(LATENCY - 1);
              stall_req <= 1'b1;
            end
          end
        end
        BUSY: begin
          if (flush || slow_done) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            stall_req <= 1'b0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FETCH_HIT_EN
  logic [29:0] tag_q;
  logic        tag_valid;

  assign hit = tag_valid && (pc == {tag_q, 2'b00});

  // A write that lands on the word being tagged on this same edge keeps the
  // entry invalid. The response on that edge carried the pre-write data.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tag_q     <= 30'd0;
      tag_valid <= 1'b0;
    end else if (resp_fire && !resp_bad) begin
      tag_q     <= resp_addr[31:2];
      tag_valid <= !(wr_ok && (waddr[31:2] == resp_addr[31:2]));
    end else if (wr_ok && (waddr[31:2] == tag_q)) begin
      tag_valid <= 1'b0;
    end
  end
`else
  assign hit = 1'b0;
`endif

endmodule

// File: doc/inst_fetch_resp.md
Name: inst_fetch_resp

Overview:
- Instruction-memory responder for the fetch stage.
- Accepts the fetch stage's chip-enable/PC request and returns a 32-bit instruction after a configurable wait.
- Holds a stall request high while a fetch is outstanding, and drops in-flight fetches on pipeline flush.
- Contains a word-addressed instruction store with a write port that the bench and the loader use to preload it.

Parameters:
- LATENCY, 3, cycles from request accept edge to instruction visible; legal range 1..8.
- DEPTH, 1024, instruction words stored; power of two.
- BASE_ADDR, 32'h3000_0000, byte address of word 0. Matches the fetch stage reset PC.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  synchronous reset, active-low.
- ce  in  1  fetch request enable from the fetch stage.
- pc  in  32  fetch byte address.
- flush  in  1  pipeline flush; aborts any outstanding fetch.
- we  in  1  store write enable (loader).
- waddr  in  32  write byte address (same mapping as pc).
- wdata  in  32  write data.
- inst  out  32  fetched instruction.
- inst_valid  out  1  one-cycle pulse when inst is new.
- stall_req  out  1  high while a fetch is outstanding; feeds stall[0] logic.
- fetch_err  out  1  qualifies inst_valid; pc misaligned or out of range.

Behaviour:
- Reset: rst low at posedge gives state IDLE, inst=32'h0000_0013 (NOP), inst_valid=0, stall_req=0, fetch_err=0, cnt=0. Store contents are not reset. Reset mid-fetch discards that fetch.
- States: IDLE, BUSY.
- Accept: in IDLE, the posedge with ce=1 and flush=0 latches pc.
- LATENCY=1: the response (inst, inst_valid=1) is registered on the accept edge. The state stays IDLE.
- LATENCY>1: the state goes to BUSY, cnt=LATENCY-1, and stall_req=1 is registered on the accept edge.
  - Each BUSY edge decrements cnt.
  - The edge where cnt==1 registers the response, with inst_valid=1, stall_req=0, state IDLE.
  - The result is inst_valid visible LATENCY cycles after the accept edge, with stall_req high for LATENCY-1 cycles.
- In BUSY, ce and pc changes are ignored because the address is latched.
- Back-to-back requests: on the response edge the block returns to IDLE. Requests with ce=1 are accepted from the next edge onward, so there is one IDLE cycle between fetches when LATENCY>1.
- Response mapping:
  - pc[1:0]!=0 gives inst=NOP, fetch_err=1.
  - pc<BASE_ADDR or word index (pc-BASE_ADDR)>>2 >= DEPTH gives inst=NOP, fetch_err=1.
  - Otherwise inst=store[index], fetch_err=0.
- The store is read on the response edge, not the accept edge.
- inst and fetch_err hold their values when inst_valid=0.
- Flush:
  - flush=1 in BUSY: return to IDLE with stall_req=0 and cnt=0 at that edge; no inst_valid for the aborted fetch.
  - flush=1 in IDLE with ce=1: the request is not accepted.
  - flush=1 on the response edge: the response is suppressed.
- Write: if we=1 and waddr is aligned and in range, store[index]<=wdata at the posedge. Out-of-range or misaligned writes are ignored.
- Same-edge write and response read: the read returns the old data.
- Arithmetic: the index subtraction is 32-bit unsigned. The range check is done before truncation to log2(DEPTH) bits.

Optional Feature:
- Macro: FETCH_HIT_EN.
- With the macro defined:
  - A one-entry tag register holds the word address of the last successful (fetch_err=0) response, plus a valid bit that reset clears.
  - An IDLE accept whose pc equals the tag completes as if LATENCY=1: response on the accept edge, no BUSY, stall_req stays 0.
  - A write to the tagged address clears the valid bit on that edge.
  - flush does not clear the tag.
- Without the macro: no tag logic exists, and every fetch takes the full LATENCY.

Test Plan (LATENCY=3, DEPTH=1024, BASE_ADDR=32'h3000_0000):
- Preload word 0 with 32'h0010_0093. Hold ce=1, pc=32'h3000_0000 from reset release. Required: stall_req high for 2 cycles, inst_valid pulses on cycle 3 with inst=32'h0010_0093 and fetch_err=0.
- Change pc to 32'h3000_0004 one cycle after accept while BUSY. Required: the response is still store[0] and the new pc is fetched only after the response.
- Assert flush on cycle 2 of a fetch of 32'h3000_0008. Required: stall_req=0 next cycle, no inst_valid, and the next request completes normally.
- pc=32'h3000_0002, then pc=32'h3000_1000, then pc=32'h2FFF_FFFC. Required: each produces inst=32'h0000_0013 with fetch_err=1 and inst_valid=1.
- Write 32'hDEAD_BEEF to 32'h3000_0010 on the response edge of a fetch of the same address. Required: the response is the old data and the following fetch returns 32'hDEAD_BEEF.
- With FETCH_HIT_EN defined, fetch 32'h3000_0000 twice. Required: the second completes on its accept edge with stall_req kept at 0. After a write to 32'h3000_0000, the next fetch takes 3 cycles again.
